packet_ingress_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single `packet_decoder` instance between `N_PORTS` ingress streams of 32-bit beats. It locks the grant for a whole packet and drives the decoder's `packet4_byte`/`data_valid`/`last_valid`/`keep` inputs. It also shapes each packet so the decoder never stalls or desynchronises:
- inserts the idle cycle the decoder needs after a 3/4-byte tail,
- enforces the MTU cut,
- pads runt packets,
- sanitises illegal `keep` values.

---
 rtl/packet_ingress_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_packet_ingress_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_ingress_arbiter.sv
// Packet-granular round-robin arbiter feeding one packet_decoder: locks grant per packet, cuts at MTU, pads runts, cleans keep, inserts tail gap.
// Latency: 1 cycle from an accepted source beat to the registered decoder outputs; arbitration costs one IDLE cycle per packet.
// Backpressure: src_ready goes only to the granted port (FWD/DROP) and never depends on src_valid; the decoder side has no ready and is never stalled.
module packet_ingress_arbiter #(
    parameter  int N_PORTS   = 4,
    parameter  int MTU_WORDS = 381,
    parameter  int MIN_WORDS = 7,
    localparam int GW        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32*N_PORTS-1:0]  src_data,
    input  logic [N_PORTS-1:0]     src_valid,
    input  logic [N_PORTS-1:0]     src_last,
    input  logic [4*N_PORTS-1:0]   src_keep,
    output logic [N_PORTS-1:0]     src_ready,
    output logic [31:0]            packet4_byte,
    output logic                   data_valid,
    output logic                   last_valid,
    output logic [3:0]             keep,
    output logic [GW-1:0]          grant_id,
    output logic                   busy,
    output logic [15:0]            trunc_cnt,
    output logic [15:0]            runt_cnt,
    output logic [15:0]            badkeep_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_PAD  = 3'd2,
        ST_DROP = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic [8:0]    MTU_CNT   = 9'(MTU_WORDS);
    localparam logic [8:0]    MIN_CNT   = 9'(MIN_WORDS);
    localparam logic [GW-1:0] LAST_PORT = GW'(N_PORTS - 1);

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [8:0]    beat_cnt_q, beat_cnt_d;
    logic [8:0]    beat_inc;

    logic [31:0]   data_q, data_d;
    logic          dv_q, dv_d;
    logic          lv_q, lv_d;
    logic [3:0]    keep_q, keep_d;

    logic [15:0]   trunc_q, trunc_d;
    logic [15:0]   runt_q, runt_d;
    logic [15:0]   badkeep_q, badkeep_d;

    // Granted port's beat, muxed out of the flat source buses
    logic [31:0]   sel_data;
    logic          sel_valid;
    logic          sel_last;
    logic [3:0]    sel_keep;
    logic          sel_keep_ok;
    logic [3:0]    fwd_keep;

    // Round-robin pick
    logic          arb_found;
    logic [GW-1:0] arb_pick;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign beat_inc = beat_cnt_q + 9'd1;

    // Select the granted port's data/valid/last/keep
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_keep  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data  = src_data[32*i +: 32];
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                sel_keep  = src_keep[4*i +: 4];
            end
        end
    end

    // Only contiguous low-byte masks are meaningful to the decoder; anything else is widened to a full word
    always_comb begin
        sel_keep_ok = (sel_keep == 4'b0000) || (sel_keep == 4'b0001) ||
                      (sel_keep == 4'b0011) || (sel_keep == 4'b0111) ||
                      (sel_keep == 4'b1111);
        fwd_keep    = sel_keep_ok ? sel_keep : 4'b1111;
    end

    // Round-robin search: lowest valid port above the last grant, else lowest valid port at or below it
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = grant_q;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!arb_found && src_valid[i] && (GW'(i) > grant_q)) begin
                arb_found = 1'b1;
                arb_pick  = GW'(i);
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            if (!arb_found && src_valid[i] && (GW'(i) <= grant_q)) begin
                arb_found = 1'b1;
                arb_pick  = GW'(i);
            end
        end
    end

    // Ready is a pure decode of registered state so sources never see a valid->ready loop
    always_comb begin
        src_ready = '0;
        if ((state_q == ST_FWD) || (state_q == ST_DROP)) begin
            for (int i = 0; i < N_PORTS; i++) begin
                src_ready[i] = (grant_q == GW'(i));
            end
        end
    end

    // Next-state, next decoder beat and counter updates
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        data_d     = '0;
        dv_d       = 1'b0;
        lv_d       = 1'b0;
        keep_d     = '0;
        trunc_d    = trunc_q;
        runt_d     = runt_q;
        badkeep_d  = badkeep_q;

        case (state_q)
            ST_IDLE: begin
                beat_cnt_d = '0;
                if (arb_found) begin
                    grant_d = arb_pick;
                    state_d = ST_FWD;
                end
            end

            ST_FWD: begin
                if (sel_valid) begin
                    dv_d       = 1'b1;
                    data_d     = sel_data;
                    keep_d     = 4'b1111;
                    beat_cnt_d = beat_inc;
                    if (sel_last) begin
                        if (beat_inc >= MIN_CNT) begin
                            lv_d   = 1'b1;
                            keep_d = fwd_keep;
                            if (!sel_keep_ok) begin
                                badkeep_d = sat_inc(badkeep_q);
                            end
                            // A 3/4-byte tail needs one extra decoder idle cycle
                            state_d = fwd_keep[2] ? ST_GAP : ST_IDLE;
                        end else begin
                            // Runt: hide the source last, the pad phase supplies the real one
                            runt_d  = sat_inc(runt_q);
                            state_d = ST_PAD;
                        end
                    end else if (beat_inc == MTU_CNT) begin
                        lv_d    = 1'b1;
                        trunc_d = sat_inc(trunc_q);
                        state_d = ST_DROP;
                    end
                end
            end

            ST_PAD: begin
                dv_d       = 1'b1;
                beat_cnt_d = beat_inc;
                if (beat_inc >= MIN_CNT) begin
                    lv_d    = 1'b1;
                    keep_d  = 4'b0000;
                    state_d = ST_IDLE;
                end else begin
                    keep_d  = 4'b1111;
                end
            end

            ST_DROP: begin
                // Swallow the rest of an over-MTU packet; at least one cycle long
                if (sel_valid && sel_last) begin
                    state_d = ST_IDLE;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, decoder output and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= LAST_PORT;
            beat_cnt_q <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            lv_q       <= 1'b0;
            keep_q     <= '0;
            trunc_q    <= '0;
            runt_q     <= '0;
            badkeep_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            lv_q       <= lv_d;
            keep_q     <= keep_d;
            trunc_q    <= trunc_d;
            runt_q     <= runt_d;
            badkeep_q  <= badkeep_d;
        end
    end

    assign packet4_byte = data_q;
    assign data_valid   = dv_q;
    assign last_valid   = lv_q;
    assign keep         = keep_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q != ST_IDLE);
    assign trunc_cnt    = trunc_q;
    assign runt_cnt     = runt_q;
    assign badkeep_cnt  = badkeep_q;

endmodule

// File: tb/tb_packet_ingress_arbiter.sv
// Bench for packet_ingress_arbiter: per-port packet queues drive the sources, a packet-level model builds the expected decoder stream.
// Latency: outputs sampled on the falling edge, inputs updated 1 time unit after the rising edge.
// Backpressure: sources hold each beat until valid&&ready; optional random stalls inside packets.
module tb_packet_ingress_arbiter;

    localparam int N    = 4;
    localparam int MTU  = 381;
    localparam int MINW = 7;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  keep;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [32*N-1:0]  src_data;
    logic [N-1:0]     src_valid;
    logic [N-1:0]     src_last;
    logic [4*N-1:0]   src_keep;
    logic [N-1:0]     src_ready;
    logic [31:0]      packet4_byte;
    logic             data_valid;
    logic             last_valid;
    logic [3:0]       keep;
    logic [1:0]       grant_id;
    logic             busy;
    logic [15:0]      trunc_cnt;
    logic [15:0]      runt_cnt;
    logic [15:0]      badkeep_cnt;

    packet_ingress_arbiter #(
        .N_PORTS   (N),
        .MTU_WORDS (MTU),
        .MIN_WORDS (MINW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_last     (src_last),
        .src_keep     (src_keep),
        .src_ready    (src_ready),
        .packet4_byte (packet4_byte),
        .data_valid   (data_valid),
        .last_valid   (last_valid),
        .keep         (keep),
        .grant_id     (grant_id),
        .busy         (busy),
        .trunc_cnt    (trunc_cnt),
        .runt_cnt     (runt_cnt),
        .badkeep_cnt  (badkeep_cnt)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;

    beat_t pq[N][$];
    bit    at_first[N];

    beat_t obs_q[$];
    int    obs_cyc[$];

    beat_t exp_q[$];
    bit    exp_chk_keep[$];
    int    exp_gap[$];

    int    m_grant;
    int    m_trunc;
    int    m_runt;
    int    m_bad;

    task automatic add_pkt(input int port, input int len, input logic [3:0] kp);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = $urandom;
            b.last = (j == len - 1);
            b.keep = (j == len - 1) ? kp : 4'($urandom_range(0, 15));
            pq[port].push_back(b);
        end
    endtask

    task automatic exp_push(input beat_t e, input bit ck, input int gap);
        exp_q.push_back(e);
        exp_chk_keep.push_back(ck);
        exp_gap.push_back(gap);
    endtask

    // Whole-packet model: round-robin over non-empty port queues, then cut / pad / sanitise each packet
    task automatic build_expected();
        beat_t      cq[N][$];
        beat_t      words[$];
        beat_t      e;
        int         idx;
        int         p;
        int         len;
        logic [3:0] kp;
        logic [3:0] sk;
        exp_q.delete();
        exp_chk_keep.delete();
        exp_gap.delete();
        for (int i = 0; i < N; i++) cq[i] = pq[i];
        for (int guard = 0; guard < 1000; guard++) begin
            idx = -1;
            for (int k = 1; k <= N; k++) begin
                p = (m_grant + k) % N;
                if (idx < 0 && cq[p].size() > 0) idx = p;
            end
            if (idx < 0) break;
            m_grant = idx;
            words.delete();
            do begin
                e = cq[idx].pop_front();
                words.push_back(e);
            end while (!e.last && cq[idx].size() > 0);
            len = words.size();
            kp  = words[len-1].keep;
            if (len > MTU) begin
                for (int j = 0; j < MTU; j++) begin
                    e.data = words[j].data;
                    e.last = (j == MTU - 1);
                    e.keep = 4'hF;
                    exp_push(e, 1'b1, (j == MTU - 1) ? (len - MTU + 1) : 0);
                end
                m_trunc++;
            end else if (len < MINW) begin
                for (int j = 0; j < len; j++) begin
                    e.data = words[j].data;
                    e.last = 1'b0;
                    e.keep = 4'hF;
                    exp_push(e, j != len - 1, 0);
                end
                for (int j = len; j < MINW; j++) begin
                    e.data = 32'd0;
                    e.last = (j == MINW - 1);
                    e.keep = 4'h0;
                    exp_push(e, j == MINW - 1, (j == MINW - 1) ? 1 : 0);
                end
                m_runt++;
            end else begin
                sk = (kp inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF}) ? kp : 4'hF;
                if (sk != kp) m_bad++;
                for (int j = 0; j < len; j++) begin
                    e.data = words[j].data;
                    e.last = (j == len - 1);
                    e.keep = (j == len - 1) ? sk : 4'hF;
                    exp_push(e, 1'b1, (j == len - 1) ? (sk[2] ? 2 : 1) : 0);
                end
            end
        end
    endtask

    task automatic drive_sources(input bit stalls);
        beat_t h;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                h = pq[i][0];
                src_valid[i]        = at_first[i] ? 1'b1 : (stalls ? ($urandom_range(0, 3) != 0) : 1'b1);
                src_data[32*i +: 32] = h.data;
                src_last[i]         = h.last;
                src_keep[4*i +: 4]  = h.keep;
            end else begin
                src_valid[i]        = 1'b0;
                src_last[i]         = 1'b0;
                src_data[32*i +: 32] = 32'd0;
                src_keep[4*i +: 4]  = 4'd0;
            end
        end
    endtask

    task automatic run_traffic(input bit stalls, input int stop_after, input int budget);
        logic [N-1:0] acc;
        beat_t        o;
        beat_t        h;
        bit           done;
        bit           empty;
        int           cyc;
        obs_q.delete();
        obs_cyc.delete();
        done = 1'b0;
        cyc  = 0;
        drive_sources(stalls);
        while (!done && cyc < budget) begin
            @(negedge clk);
            if (data_valid) begin
                o.data = packet4_byte;
                o.last = last_valid;
                o.keep = keep;
                obs_q.push_back(o);
                obs_cyc.push_back(cyc);
            end
            if (stop_after > 0 && obs_q.size() == stop_after) return;
            acc = src_valid & src_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    h = pq[i].pop_front();
                    at_first[i] = h.last;
                end
            end
            drive_sources(stalls);
            cyc++;
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (pq[i].size() > 0) empty = 1'b0;
            if (empty && !busy && !data_valid) done = 1'b1;
        end
        checks++;
        if (!done || stop_after > 0) begin
            errors++;
            $display("FAIL run_timeout: stopped after %0d cycles with %0d beats seen, required completion (stop_after=%0d)",
                     cyc, obs_q.size(), stop_after);
        end
    endtask

    // Scoreboard: observed decoder beats against the model stream, plus idle spacing when sources never stall
    task automatic scoreboard(input bit chk_gaps);
        int n;
        int g;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL beat_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last ||
                (exp_chk_keep[i] && obs_q[i].keep !== exp_q[i].keep)) begin
                errors++;
                $display("FAIL beat[%0d]: got data=%h last=%b keep=%b, expected data=%h last=%b keep=%b",
                         i, obs_q[i].data, obs_q[i].last, obs_q[i].keep,
                         exp_q[i].data, exp_q[i].last, exp_q[i].keep);
            end
        end
        if (chk_gaps) begin
            for (int i = 0; i < n - 1; i++) begin
                g = obs_cyc[i+1] - obs_cyc[i] - 1;
                checks++;
                if (g != exp_gap[i]) begin
                    errors++;
                    $display("FAIL idle_gap[%0d]: got %0d idle cycles, expected %0d", i, g, exp_gap[i]);
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            at_first[i] = 1'b1;
        end
        drive_sources(1'b0);
        m_grant = N - 1;
        m_trunc = 0;
        m_runt  = 0;
        m_bad   = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({packet4_byte, data_valid, last_valid, keep} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h dv=%b lv=%b keep=%b, expected all 0",
                     packet4_byte, data_valid, last_valid, keep);
        end
        checks++;
        if (src_ready !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_busy: got ready=%b busy=%b, expected 0000/0", src_ready, busy);
        end
        checks++;
        if (grant_id !== 2'(N - 1)) begin
            errors++;
            $display("FAIL reset_grant: got %0d, expected %0d", grant_id, N - 1);
        end
        checks++;
        if ({trunc_cnt, runt_cnt, badkeep_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0", trunc_cnt, runt_cnt, badkeep_cnt);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0 || src_ready !== 4'd0) begin
            errors++;
            $display("FAIL idle_no_requests: got busy=%b dv=%b ready=%b, expected 0/0/0000", busy, data_valid, src_ready);
        end
    endtask

    task automatic test_gap();
        add_pkt(1, 9, 4'hF);
        add_pkt(3, 8, 4'h1);
        build_expected();
        run_traffic(1'b0, 0, 500);
        scoreboard(1'b1);
        checks++;
        if (grant_id !== 2'(m_grant) || busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_grant: got grant=%0d busy=%b, expected %0d/0", grant_id, busy, m_grant);
        end
    endtask

    task automatic test_two_ports();
        add_pkt(0, 10, 4'h3);
        add_pkt(2, 10, 4'h3);
        build_expected();
        run_traffic(1'b0, 0, 500);
        scoreboard(1'b1);
        checks++;
        if (grant_id !== 2'd2) begin
            errors++;
            $display("FAIL two_ports_grant: got %0d, expected 2", grant_id);
        end
    endtask

    task automatic test_mtu();
        add_pkt(0, 400, 4'h3);
        add_pkt(1, 8, 4'h1);
        build_expected();
        run_traffic(1'b0, 0, 2000);
        scoreboard(1'b1);
        checks++;
        if (trunc_cnt !== 16'(m_trunc)) begin
            errors++;
            $display("FAIL trunc_cnt: got %0d, expected %0d", trunc_cnt, m_trunc);
        end
    endtask

    task automatic test_runt();
        add_pkt(2, 4, 4'h7);
        build_expected();
        run_traffic(1'b0, 0, 500);
        scoreboard(1'b1);
        checks++;
        if (runt_cnt !== 16'(m_runt)) begin
            errors++;
            $display("FAIL runt_cnt: got %0d, expected %0d", runt_cnt, m_runt);
        end
    endtask

    task automatic test_badkeep();
        add_pkt(3, 8, 4'b0101);
        add_pkt(0, 7, 4'h3);
        build_expected();
        run_traffic(1'b0, 0, 500);
        scoreboard(1'b1);
        checks++;
        if (badkeep_cnt !== 16'(m_bad)) begin
            errors++;
            $display("FAIL badkeep_cnt: got %0d, expected %0d", badkeep_cnt, m_bad);
        end
    endtask

    task automatic test_length_edges();
        add_pkt(1, MTU, 4'h7);
        add_pkt(2, MTU + 1, 4'h1);
        add_pkt(3, MINW, 4'h1);
        add_pkt(0, MINW - 1, 4'hF);
        add_pkt(0, 1, 4'h0);
        build_expected();
        run_traffic(1'b0, 0, 3000);
        scoreboard(1'b1);
        checks++;
        if ({trunc_cnt, runt_cnt, badkeep_cnt} !== {16'(m_trunc), 16'(m_runt), 16'(m_bad)}) begin
            errors++;
            $display("FAIL edge_counters: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                     trunc_cnt, runt_cnt, badkeep_cnt, m_trunc, m_runt, m_bad);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) add_pkt(2, 8 + k, 4'(k == 1 ? 4'h7 : 4'h3));
        add_pkt(1, 9, 4'h0);
        build_expected();
        run_traffic(1'b0, 0, 500);
        scoreboard(1'b1);
        checks++;
        if (grant_id !== 2'(m_grant) || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_grant: got grant=%0d busy=%b, expected %0d/0", grant_id, busy, m_grant);
        end
    endtask

    task automatic test_random();
        int n;
        int len;
        for (int r = 0; r < 20; r++) begin
            n = 0;
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int k = 0; k < $urandom_range(1, 2); k++) begin
                        len = ($urandom_range(0, 14) == 0) ? $urandom_range(MTU - 2, MTU + 6) : $urandom_range(1, 16);
                        add_pkt(p, len, 4'($urandom_range(0, 15)));
                        n++;
                    end
                end
            end
            if (n == 0) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 16), 4'($urandom_range(0, 15)));
            build_expected();
            run_traffic(1'b1, 0, 20000);
            scoreboard(1'b0);
            checks++;
            if ({trunc_cnt, runt_cnt, badkeep_cnt} !== {16'(m_trunc), 16'(m_runt), 16'(m_bad)} ||
                grant_id !== 2'(m_grant)) begin
                errors++;
                $display("FAIL random_state[%0d]: got counters %0d/%0d/%0d grant %0d, expected %0d/%0d/%0d grant %0d",
                         r, trunc_cnt, runt_cnt, badkeep_cnt, grant_id, m_trunc, m_runt, m_bad, m_grant);
            end
        end
    endtask

    task automatic test_reset_mid();
        add_pkt(0, 12, 4'h3);
        add_pkt(3, 12, 4'h1);
        run_traffic(1'b0, 5, 200);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({packet4_byte, data_valid, last_valid, keep} !== 38'd0 || src_ready !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got data=%h dv=%b lv=%b keep=%b ready=%b busy=%b, expected all 0",
                     packet4_byte, data_valid, last_valid, keep, src_ready, busy);
        end
        checks++;
        if (grant_id !== 2'(N - 1) || {trunc_cnt, runt_cnt, badkeep_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL midreset_state: got grant=%0d counters %0d/%0d/%0d, expected %0d and 0/0/0",
                     grant_id, trunc_cnt, runt_cnt, badkeep_cnt, N - 1);
        end
        apply_reset();
        rst = 1'b1;
        add_pkt(3, 8, 4'h1);
        add_pkt(0, 8, 4'h3);
        build_expected();
        run_traffic(1'b0, 0, 500);
        scoreboard(1'b1);
        checks++;
        if (grant_id !== 2'd3) begin
            errors++;
            $display("FAIL midreset_order: got final grant %0d, expected 3 (port 0 served first)", grant_id);
        end
    endtask

    initial begin
        rst       = 1'b0;
        src_data  = '0;
        src_valid = '0;
        src_last  = '0;
        src_keep  = '0;
        test_reset();
        test_gap();
        test_two_ports();
        test_mtu();
        test_runt();
        test_badkeep();
        test_length_edges();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks %0d errors so far", checks, errors);
        $fatal(1);
    end

endmodule
